regfile_dumper: RTL

Debug read-out engine for the CPU register file. On a start pulse it walks all register addresses through a spare register-file read port, captures each 32-bit value, and streams the contents as a framed byte sequence over a valid/ready byte interface. The sink is typically the UART transmitter. It sits beside the register file as a pure reader and never drives write enable or write data.

---
 rtl/regfile_dumper.sv | 119 +++++++++++
 1 files changed

// File: rtl/regfile_dumper.sv
// Debug read-out engine: walks the register file through a spare read port and
// streams HEADER, every register MSB-first, then an XOR checksum over a byte handshake.
module regfile_dumper #(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter logic [7:0]  HEADER   = 8'hA5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [31:0]       rd_data,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_LOAD,
    S_SEND,
    S_SUM
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  state_t            state_q;
  logic [ADDR_W-1:0] idx_q;
  logic [1:0]        byte_cnt_q;
  logic [31:0]       shift_q;
  logic [7:0]        csum_q;
  logic              busy_q;
  logic              done_q;
  logic              tx_valid_q;
  logic [7:0]        tx_data_q;
  logic              xfer;

  assign xfer     = tx_valid_q & tx_ready;
  assign busy     = busy_q;
  assign done     = done_q;
  assign tx_valid = tx_valid_q;
  assign tx_data  = tx_data_q;
  assign rd_addr  = idx_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      byte_cnt_q <= '0;
      shift_q    <= '0;
      csum_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          idx_q  <= '0;
          csum_q <= '0;
          if (start) begin
            state_q    <= S_HDR;
            busy_q     <= 1'b1;
            tx_valid_q <= 1'b1;
            tx_data_q  <= HEADER;
          end
        end
        S_HDR: begin
          if (xfer) begin
            state_q    <= S_LOAD;
            tx_valid_q <= 1'b0;
          end
        end
        S_LOAD: begin
          // The first byte is presented straight from rd_data so SEND starts valid.
          shift_q    <= rd_data;
          byte_cnt_q <= '0;
          tx_data_q  <= rd_data[31:24];
          tx_valid_q <= 1'b1;
          state_q    <= S_SEND;
        end
        S_SEND: begin
          if (xfer) begin
            csum_q     <= csum_q ^ shift_q[31:24];
            shift_q    <= {shift_q[23:0], 8'h00};
            byte_cnt_q <= byte_cnt_q + 2'd1;
            if (byte_cnt_q != 2'd3) begin
              tx_data_q <= shift_q[23:16];
            end else if (idx_q == LAST_IDX) begin
              state_q   <= S_SUM;
              tx_data_q <= csum_q ^ shift_q[31:24];
            end else begin
              idx_q      <= idx_q + 1'b1;
              tx_valid_q <= 1'b0;
              state_q    <= S_LOAD;
            end
          end
        end
        S_SUM: begin
          if (xfer) begin
            state_q    <= S_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
            idx_q      <= '0;
            csum_q     <= '0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
